// File: rtl/lsu.sv
// Load/store unit for a single-cycle RISC-V core.
// Handles 2 KiB of word-organised data memory and a few memory-mapped I/O registers.
//
// Memory map (each register is decoded on addr_i[31:2]):
//   0x0000_0000-0x0000_07FF DMEM, 512 x 32
//   0x1000_0000 LEDR, 0x1000_1000 LEDG, 0x1000_2000 HEX0-3, 0x1000_2004 HEX4-7
//   0x1001_0000 SW, read-only and synchronised
//   Reads from any other address return 0, and stores to them are dropped.
//
// Ports:
//   clk_i, rst_ni     clock and synchronous active-low reset
//   addr_i            byte address
//   st_data_i         store data, right-aligned
//   st_en_i           store request
//   lsu_op_i          funct3 of the load or store
//   ld_data_o         combinational, extended load data
//   io_sw_i           asynchronous switch inputs
//   io_ledr_o         LED register
//   io_ledg_o         LED register
//   io_hex_o          seven-segment registers; byte n drives HEXn
//   misalign_o        sticky misalignment flag
//
// Optional feature, selected by the macro LSU_MISALIGN_CHK_EN:
//   When the macro is defined, misaligned accesses are detected, dropped and flagged.
//   When the macro is undefined, the low address bits are ignored, which forces
//   alignment, and misalign_o is tied to 0.
module lsu (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_data_i,
  input  logic        st_en_i,
  input  logic [2:0]  lsu_op_i,
  output logic [31:0] ld_data_o,
  input  logic [31:0] io_sw_i,
  output logic [31:0] io_ledr_o,
  output logic [31:0] io_ledg_o,
  output logic [63:0] io_hex_o,
  output logic        misalign_o
);

  localparam logic [29:0] LedrWord  = 30'h0400_0000;
  localparam logic [29:0] LedgWord  = 30'h0400_0400;
  localparam logic [29:0] HexLoWord = 30'h0400_0800;
  localparam logic [29:0] HexHiWord = 30'h0400_0801;
  localparam logic [29:0] SwWord    = 30'h0400_4000;

  logic [31:0] dmem [512];
  logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d;
  logic [63:0] hex_q, hex_d;
  logic [31:0] sw_sync1_q, sw_sync2_q;

  logic        sel_dmem, sel_ledr, sel_ledg, sel_hex_lo, sel_hex_hi, sel_sw;
  logic        access_mis;
  logic [31:0] rd_word, wr_data;
  logic [3:0]  be;
  logic        st_req, we;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    sel_dmem   = (addr_i[31:11] == 21'd0);
    sel_ledr   = (addr_i[31:2] == LedrWord);
    sel_ledg   = (addr_i[31:2] == LedgWord);
    sel_hex_lo = (addr_i[31:2] == HexLoWord);
    sel_hex_hi = (addr_i[31:2] == HexHiWord);
    sel_sw     = (addr_i[31:2] == SwWord);
  end

`ifdef LSU_MISALIGN_CHK_EN
  // Halfword ops have funct3[1:0]=01 and word ops have 10, for both loads and stores.
  assign access_mis = ((lsu_op_i[1:0] == 2'b01) && addr_i[0]) ||
                      ((lsu_op_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
  assign access_mis = 1'b0;
`endif

  // Read path: this is purely combinational and returns the contents before any store (write-after-read).
  always_comb begin
    rd_word = '0;
    if (sel_dmem)        rd_word = dmem[addr_i[10:2]];
    else if (sel_ledr)   rd_word = ledr_q;
    else if (sel_ledg)   rd_word = ledg_q;
    else if (sel_hex_lo) rd_word = hex_q[31:0];
    else if (sel_hex_hi) rd_word = hex_q[63:32];
    else if (sel_sw)     rd_word = sw_sync2_q;
  end

  always_comb begin
    rd_byte   = rd_word[{addr_i[1:0], 3'b000} +: 8];
    rd_half   = addr_i[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data_o = '0;
    case (lsu_op_i)
      3'b000:  ld_data_o = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data_o = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data_o = rd_word;
      3'b100:  ld_data_o = {24'd0, rd_byte};
      3'b101:  ld_data_o = {16'd0, rd_half};
      default: ld_data_o = '0;
    endcase
    if (access_mis) ld_data_o = '0;
  end

  // Store path: the store data is replicated to every lane, and the byte enables select which lanes are written.
  always_comb begin
    be      = 4'b0000;
    wr_data = st_data_i;
    case (lsu_op_i)
      3'b000: begin
        be      = 4'b0001 << addr_i[1:0];
        wr_data = {4{st_data_i[7:0]}};
      end
      3'b001: begin
        be      = addr_i[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{st_data_i[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    st_req = st_en_i && (be != 4'b0000);
    we     = st_req && rst_ni && !access_mis;
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] lanes);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = lanes[i] ? wd[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    hex_d  = hex_q;
    if (we && sel_ledr)   ledr_d         = merge(ledr_q, wr_data, be);
    if (we && sel_ledg)   ledg_d         = merge(ledg_q, wr_data, be);
    if (we && sel_hex_lo) hex_d[31:0]    = merge(hex_q[31:0], wr_data, be);
    if (we && sel_hex_hi) hex_d[63:32]   = merge(hex_q[63:32], wr_data, be);
  end

  // DMEM has no reset. The rst_ni gate is folded into we.
  always_ff @(posedge clk_i) begin
    if (we && sel_dmem) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) dmem[addr_i[10:2]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ledr_q     <= '0;
      ledg_q     <= '0;
      hex_q      <= '0;
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      hex_q      <= hex_d;
      sw_sync1_q <= io_sw_i;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  assign io_ledr_o = ledr_q;
  assign io_ledg_o = ledg_q;
  assign io_hex_o  = hex_q;

`ifdef LSU_MISALIGN_CHK_EN
  // Loads have no request strobe, so only a real store request can raise the flag.
  logic misalign_q, misalign_d;
  assign misalign_d = misalign_q | (st_req && access_mis);
  always_ff @(posedge clk_i) begin
    if (!rst_ni) misalign_q <= 1'b0;
    else         misalign_q <= misalign_d;
  end
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_en = 1'b0;
  logic [2:0]  op = 3'b010;
  logic [31:0] addr = 32'h2000_0000;
  logic [31:0] st_data = '0;
  logic [31:0] sw = '0;
  logic [31:0] ld_data, ledr, ledg;
  logic [63:0] hex;
  logic        misalign;

  always #5 clk = ~clk;

  lsu dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .addr_i     (addr),
    .st_data_i  (st_data),
    .st_en_i    (st_en),
    .lsu_op_i   (op),
    .ld_data_o  (ld_data),
    .io_sw_i    (sw),
    .io_ledr_o  (ledr),
    .io_ledg_o  (ledg),
    .io_hex_o   (hex),
    .misalign_o (misalign)
  );

  localparam logic [31:0] LedrA = 32'h1000_0000;
  localparam logic [31:0] LedgA = 32'h1000_1000;
  localparam logic [31:0] Hex0A = 32'h1000_2000;
  localparam logic [31:0] Hex4A = 32'h1000_2004;
  localparam logic [31:0] SwA   = 32'h1001_0000;

  // Scoreboard entries: kind 0=ld_data 1=ledr 2=ledg 3=hex lo 4=hex hi 5=misalign
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;
  chk_t sbq[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: byte-addressed storage, plus the synchroniser pipeline
  logic [7:0]  mm [bit [31:0]];
  logic [31:0] s1_m = '0, s2_m = '0;
  bit          mis_m = 1'b0;

  function automatic int sz(input logic [2:0] o, input bit is_st);
    if (is_st) return (o == 3'd0) ? 1 : (o == 3'd1) ? 2 : (o == 3'd2) ? 4 : 0;
    case (o)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit writable(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'd3;
    return (a < 32'h800) || w == LedrA || w == LedgA || w == Hex0A || w == Hex4A;
  endfunction

  function automatic bit misal(input logic [31:0] a, input int n);
`ifdef LSU_MISALIGN_CHK_EN
    return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Returns 0 when the result depends on DMEM bytes that were never written.
  function automatic bit model_ld(input logic [31:0] a, input logic [2:0] o,
                                  output logic [31:0] v);
    int n;
    logic [31:0] base, ba, raw;
    logic [7:0] b;
    n = sz(o, 1'b0);
    v = '0;
    raw = '0;
    if (n == 0 || misal(a, n)) return 1'b1;
    base = a & ~(n - 1);
    for (int i = 0; i < n; i++) begin
      ba = base + i;
      if ((ba & ~32'd3) == SwA) b = s2_m[8*ba[1:0] +: 8];
      else if (writable(ba)) begin
        if (!mm.exists(ba)) return 1'b0;
        b = mm[ba];
      end else b = 8'h00;
      raw = raw | (32'(b) << (8 * i));
    end
    if (!o[2] && n == 1) v = {{24{raw[7]}}, raw[7:0]};
    else if (!o[2] && n == 2) v = {{16{raw[15]}}, raw[15:0]};
    else v = raw;
    return 1'b1;
  endfunction

  function automatic logic [31:0] reg_word(input logic [31:0] base);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = mm[base + i];
    return r;
  endfunction

  // Applies what the DUT sees at a rising edge, using the inputs currently driven.
  task automatic model_edge();
    int n;
    logic [31:0] base;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mm[LedrA + i] = 8'h00;
        mm[LedgA + i] = 8'h00;
        mm[Hex0A + i] = 8'h00;
        mm[Hex4A + i] = 8'h00;
      end
      s1_m  = '0;
      s2_m  = '0;
      mis_m = 1'b0;
    end else begin
      n = sz(op, 1'b1);
      if (st_en && n != 0) begin
        if (misal(addr, n)) mis_m = 1'b1;
        else if (writable(addr)) begin
          base = addr & ~(n - 1);
          for (int i = 0; i < n; i++) mm[base + i] = st_data[8*i +: 8];
        end
      end
      s2_m = s1_m;
      s1_m = sw;
    end
  endtask

  task automatic push(input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sbq.push_back(c);
  endtask

  task automatic step(input logic r, input logic s, input logic [2:0] o,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] w);
    logic [31:0] v;
    @(posedge clk);
    model_edge();
    #1;
    rst_n = r; st_en = s; op = o; addr = a; st_data = d; sw = w;
    if (model_ld(addr, op, v)) push(0, v, "model_ld");
    push(1, reg_word(LedrA), "model_ledr");
    push(2, reg_word(LedgA), "model_ledg");
    push(3, reg_word(Hex0A), "model_hex_lo");
    push(4, reg_word(Hex4A), "model_hex_hi");
    push(5, {31'd0, mis_m}, "model_misalign");
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares every queued expectation against the outputs, away from the rising edge.
  initial begin
    chk_t c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        c = sbq.pop_front();
        case (c.kind)
          0:       act = ld_data;
          1:       act = ledr;
          2:       act = ledg;
          3:       act = hex[31:0];
          4:       act = hex[63:32];
          default: act = {31'd0, misalign};
        endcase
        check(c.name, act, c.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, cur_sw;
    int k;
    // Reset; the model checks that every I/O register reads 0.
    step(0, 0, 3'd2, 32'h2000_0000, 0, 0);
    step(0, 0, 3'd2, LedrA, 0, 0);
    push(1, 32'h0, "reset_ledr");
    push(0, 32'h0, "reset_ld_ledr");
    // Write every DMEM word that the random phase can load from.
    for (int i = 0; i < 16; i++) step(1, 1, 3'd2, i * 4, $urandom, 0);

    // Sub-word loads
    step(1, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0);
    step(1, 0, 3'd0, 32'h13, 0, 0); push(0, 32'hFFFF_FFDE, "lb_0x13");
    step(1, 0, 3'd4, 32'h13, 0, 0); push(0, 32'h0000_00DE, "lbu_0x13");
    step(1, 0, 3'd1, 32'h10, 0, 0); push(0, 32'hFFFF_BEEF, "lh_0x10");
    // Byte merge, then write-after-read within a single cycle
    step(1, 1, 3'd2, 32'h10, 32'h1122_3344, 0);
    step(1, 1, 3'd0, 32'h11, 32'h0000_00A5, 0);
    step(1, 0, 3'd2, 32'h10, 0, 0); push(0, 32'h1122_A544, "sb_merge");
    step(1, 1, 3'd2, 32'h10, 32'hCAFE_F00D, 0); push(0, 32'h1122_A544, "war_same_cycle");
    step(1, 0, 3'd2, 32'h10, 0, 0); push(0, 32'hCAFE_F00D, "war_next_cycle");
    // Switch synchroniser latency
    for (int i = 0; i < 3; i++) step(1, 0, 3'd2, SwA, 0, 32'h55);
    step(1, 0, 3'd2, SwA, 0, 32'hFF); push(0, 32'h55, "sw_edge_k");
    step(1, 0, 3'd2, SwA, 0, 32'hFF); push(0, 32'h55, "sw_edge_k1");
    step(1, 0, 3'd2, SwA, 0, 32'hFF); push(0, 32'hFF, "sw_edge_k2");
    // A reset wins over a simultaneous store.
    step(1, 1, 3'd2, LedrA, 32'h1234_5678, 32'hFF);
    step(1, 1, 3'd1, Hex4A + 2, 32'h0000_9A9A, 32'hFF);
    push(1, 32'h1234_5678, "ledr_written");
    step(0, 1, 3'd2, LedrA, 32'hFFFF_FFFF, 32'hFF);
    step(1, 0, 3'd2, LedrA, 0, 32'hFF);
    push(1, 32'h0, "ledr_after_reset"); push(4, 32'h0, "hex_hi_after_reset");
    push(0, 32'h0, "ld_ledr_after_reset");
    // Unmapped store and load
    step(1, 1, 3'd2, LedgA, 32'hA1A2_A3A4, 0);
    step(1, 1, 3'd0, Hex0A + 1, 32'h0000_003C, 0);
    step(1, 1, 3'd2, 32'h2000_0000, 32'h7777_7777, 0);
    step(1, 0, 3'd2, 32'h2000_0000, 0, 0);
    push(0, 32'h0, "unmapped_ld"); push(1, 32'h0, "unmapped_ledr");
    push(2, 32'hA1A2_A3A4, "unmapped_ledg"); push(3, 32'h0000_3C00, "unmapped_hex_lo");
    step(1, 1, 3'd2, SwA, 32'h1234_5678, 0);
    step(1, 0, 3'd2, SwA, 0, 0); push(0, 32'h0, "sw_readonly");
`ifdef LSU_MISALIGN_CHK_EN
    step(1, 1, 3'd2, 32'h0, 32'h0BAD_F00D, 0);
    step(1, 1, 3'd2, 32'h2, 32'hFFFF_FFFF, 0); push(5, 32'h0, "mis_before_edge");
    step(1, 0, 3'd2, 32'h0, 0, 0);
    push(0, 32'h0BAD_F00D, "mis_store_dropped"); push(5, 32'h1, "mis_set");
    step(1, 0, 3'd1, 32'h1, 0, 0); push(0, 32'h0, "mis_ld_zero"); push(5, 32'h1, "mis_held");
    step(0, 0, 3'd2, 32'h0, 0, 0);
    step(1, 0, 3'd2, 32'h0, 0, 0); push(5, 32'h0, "mis_cleared");
`endif

    // Randomised traffic, compared against the model
    cur_sw = 32'h0;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3, 4: a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        5:             a = LedrA;
        6:             a = LedgA;
        7:             a = Hex0A;
        8:             a = Hex4A;
        default:       a = ($urandom_range(0, 1) == 1) ? SwA : 32'h1000_0008;
      endcase
      a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) cur_sw = $urandom;
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)), a, $urandom, cur_sw);
    end
    step(1, 0, 3'd2, 32'h2000_0000, 0, cur_sw);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
